// File: rtl/button_debounce_arbiter.sv
// ---------------------------------------------------------------------------
// button_debounce_arbiter
//
// Conditions N_CH player buttons from two asynchronous sources (local board
// buttons and buttons relayed from a remote board). Each source bit is
// synchronised, edge-detected and arbitrated with fixed lowest-index
// priority. At most one one-cycle pulse is issued per cycle. In local mode
// an accepted pulse starts a lockout window that rejects bounce and repeat
// presses for LOCKOUT cycles.
//
// Parameters:
//   N_CH        number of button channels, channel 0 has highest priority
//   LOCKOUT     lockout length in cycles after an accepted local pulse (0 = off)
//   SYNC_STAGES synchroniser depth per input bit (>= 2)
//   EDGE_FALL   1 = falling edges / idle-high buttons, 0 = rising / idle-low
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   local_en     1 = local source drives pulses (with lockout), 0 = remote
//   btn_local    raw local buttons
//   btn_remote   raw remote buttons
//   pulse        registered one-hot (or zero) accepted-event pulse
//   event_valid  registered, equals |pulse
//   event_idx    index of the last accepted event (held while idle)
//   level        synchronised level of the currently selected source
//   busy         lockout counter non-zero
// ---------------------------------------------------------------------------
module button_debounce_arbiter #(
    parameter int  N_CH        = 3,
    parameter int  LOCKOUT     = 15,
    parameter int  SYNC_STAGES = 2,
    parameter int  EDGE_FALL   = 1,
    localparam int IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             local_en,
    input  logic [N_CH-1:0]  btn_local,
    input  logic [N_CH-1:0]  btn_remote,
    output logic [N_CH-1:0]  pulse,
    output logic             event_valid,
    output logic [IDX_W-1:0] event_idx,
    output logic [N_CH-1:0]  level,
    output logic             busy
);

    localparam int CNT_W = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
    localparam int FL_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [N_CH-1:0] IDLE_V = (EDGE_FALL != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    // Transition from idle level to active level on each bit.
    function automatic logic [N_CH-1:0] active_edge(input logic [N_CH-1:0] cur,
                                                    input logic [N_CH-1:0] prev);
        return (cur ^ IDLE_V) & ~(prev ^ IDLE_V);
    endfunction

    // Fixed priority: keep only the lowest set bit.
    function automatic logic [N_CH-1:0] first_onehot(input logic [N_CH-1:0] v);
        logic [N_CH-1:0] r;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] first_idx(input logic [N_CH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0][N_CH-1:0] loc_sync_q;
    logic [SYNC_STAGES-1:0][N_CH-1:0] rem_sync_q;
    logic [N_CH-1:0]                  loc_prev_q;
    logic [N_CH-1:0]                  rem_prev_q;
    logic [N_CH-1:0]                  loc_last;
    logic [N_CH-1:0]                  rem_last;
    logic [N_CH-1:0]                  cand;
    logic [N_CH-1:0]                  pulse_q;
    logic [N_CH-1:0]                  pulse_d;
    logic                             ev_q;
    logic                             ev_d;
    logic [IDX_W-1:0]                 idx_q;
    logic [IDX_W-1:0]                 idx_d;
    logic [CNT_W-1:0]                 cnt_q;
    logic [CNT_W-1:0]                 cnt_d;
    logic [FL_W-1:0]                  fl_q;
    logic [FL_W-1:0]                  fl_d;
    logic                             accept;

    assign loc_last = loc_sync_q[SYNC_STAGES-1];
    assign rem_last = rem_sync_q[SYNC_STAGES-1];

    // Synchroniser chains and edge registers: both sources always run, so a
    // mode switch can never manufacture an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            loc_sync_q <= {SYNC_STAGES{IDLE_V}};
            rem_sync_q <= {SYNC_STAGES{IDLE_V}};
            loc_prev_q <= IDLE_V;
            rem_prev_q <= IDLE_V;
        end else begin
            loc_sync_q <= {loc_sync_q[SYNC_STAGES-2:0], btn_local};
            rem_sync_q <= {rem_sync_q[SYNC_STAGES-2:0], btn_remote};
            loc_prev_q <= loc_last;
            rem_prev_q <= rem_last;
        end
    end

    // Arbitration, lockout counter and post-reset flush window.
    // The chains reset to idle, so a button held through reset release would
    // otherwise look like a fresh press once its real level propagates. Edges
    // are ignored until the chain and edge register have both been refilled
    // from the live input (SYNC_STAGES+1 cycles).
    always_comb begin
        cand    = local_en ? active_edge(loc_last, loc_prev_q)
                           : active_edge(rem_last, rem_prev_q);
        if (fl_q != '0) begin
            cand = '0;
        end
        accept  = (|cand) && (!local_en || (cnt_q == '0));
        pulse_d = accept ? first_onehot(cand) : '0;
        ev_d    = accept;
        idx_d   = accept ? first_idx(cand) : idx_q;

        cnt_d = cnt_q;
        if (accept && local_en) begin
            cnt_d = CNT_W'(LOCKOUT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        fl_d = fl_q;
        if (fl_q != '0) begin
            fl_d = fl_q - FL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pulse_q <= '0;
            ev_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            fl_q    <= FL_W'(SYNC_STAGES + 1);
        end else begin
            pulse_q <= pulse_d;
            ev_q    <= ev_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
        end
    end

    assign pulse       = pulse_q;
    assign event_valid = ev_q;
    assign event_idx   = idx_q;
    assign level       = local_en ? loc_last : rem_last;
    assign busy        = (cnt_q != '0);

endmodule

// File: tb/tb_button_debounce_arbiter.sv
module tb_button_debounce_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       local_en;
    logic [2:0] btn_local;
    logic [2:0] btn_remote;
    logic [2:0] pulse;
    logic       event_valid;
    logic [1:0] event_idx;
    logic [2:0] level;
    logic       busy;

    logic       le8;
    logic [7:0] b8l;
    logic [7:0] b8r;
    logic [7:0] pulse8;
    logic       ev8;
    logic [2:0] idx8;
    logic [7:0] level8;
    logic       busy8;

    int checks = 0;
    int errors = 0;

    logic [2:0] bounce_tab [10];
    logic [2:0] exp_p;
    logic [7:0] exp_p8;

    always #5 clk = ~clk;

    button_debounce_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .local_en    (local_en),
        .btn_local   (btn_local),
        .btn_remote  (btn_remote),
        .pulse       (pulse),
        .event_valid (event_valid),
        .event_idx   (event_idx),
        .level       (level),
        .busy        (busy)
    );

    button_debounce_arbiter #(
        .N_CH        (8),
        .LOCKOUT     (0),
        .SYNC_STAGES (3),
        .EDGE_FALL   (0)
    ) dut8 (
        .clk         (clk),
        .rst         (rst),
        .local_en    (le8),
        .btn_local   (b8l),
        .btn_remote  (b8r),
        .pulse       (pulse8),
        .event_valid (ev8),
        .event_idx   (idx8),
        .level       (level8),
        .busy        (busy8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bounce_tab = '{3'b110, 3'b111, 3'b110, 3'b111, 3'b110,
                       3'b111, 3'b111, 3'b111, 3'b101, 3'b101};
        rst        = 1'b0;
        local_en   = 1'b1;
        btn_local  = 3'b111;
        btn_remote = 3'b111;
        le8        = 1'b1;
        b8l        = 8'h00;
        b8r        = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_valid", 32'(event_valid), 32'h0);
        chk("rst_idx", 32'(event_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_level", 32'(level), 32'h7);
        chk("rst_level8", 32'(level8), 32'h0);
        chk("rst_busy8", 32'(busy8), 32'h0);
        rst = 1'b1;
        repeat (5) tick();

        // Single local press on ch1
        btn_local = 3'b101;
        tick();
        tick();
        chk("single_early", 32'(pulse), 32'h0);
        chk("single_level", 32'(level), 32'h5);
        tick();
        chk("single_pulse", 32'(pulse), 32'h2);
        chk("single_valid", 32'(event_valid), 32'h1);
        chk("single_idx", 32'(event_idx), 32'h1);
        chk("single_busy0", 32'(busy), 32'h1);
        tick();
        chk("single_once", 32'(pulse), 32'h0);
        chk("single_valid_lo", 32'(event_valid), 32'h0);
        chk("single_idx_hold", 32'(event_idx), 32'h1);
        repeat (13) tick();
        chk("single_busy_last", 32'(busy), 32'h1);
        tick();
        chk("single_busy_end", 32'(busy), 32'h0);
        btn_local = 3'b111;
        repeat (4) tick();

        // Simultaneous ch2 + ch0 press, both held
        btn_local = 3'b010;
        repeat (3) tick();
        chk("simul_pulse", 32'(pulse), 32'h1);
        chk("simul_idx", 32'(event_idx), 32'h0);
        for (int j = 0; j < 25; j++) begin
            tick();
            chk("simul_no_more", 32'(event_valid), 32'h0);
        end
        btn_local = 3'b111;
        repeat (3) tick();

        // Bounce on ch0, ch1 press at +8 inside lockout
        for (int j = 0; j < 30; j++) begin
            btn_local = (j < 10) ? bounce_tab[j] : bounce_tab[9];
            tick();
            exp_p = (j == 2) ? 3'b001 : 3'b000;
            chk("bounce_pulse", 32'(pulse), 32'(exp_p));
        end
        btn_local = 3'b111;
        repeat (3) tick();

        // ch1 press landing at pulse+15: dropped
        for (int j = 0; j < 25; j++) begin
            if (j == 0) btn_local = 3'b110;
            if (j == 15) btn_local = 3'b100;
            tick();
            exp_p = (j == 2) ? 3'b001 : 3'b000;
            chk("edge15_pulse", 32'(pulse), 32'(exp_p));
            if (j == 16) chk("edge15_busy_on", 32'(busy), 32'h1);
            if (j == 17) chk("edge15_busy_off", 32'(busy), 32'h0);
        end
        btn_local = 3'b111;
        repeat (3) tick();

        // ch1 press landing at pulse+16: accepted
        for (int j = 0; j < 25; j++) begin
            if (j == 0) btn_local = 3'b110;
            if (j == 16) btn_local = 3'b100;
            tick();
            exp_p = (j == 2) ? 3'b001 : ((j == 18) ? 3'b010 : 3'b000);
            chk("edge16_pulse", 32'(pulse), 32'(exp_p));
            if (j == 18) begin
                chk("edge16_idx", 32'(event_idx), 32'h1);
                chk("edge16_busy", 32'(busy), 32'h1);
            end
        end
        btn_local = 3'b111;
        repeat (16) tick();
        chk("pre_remote_busy", 32'(busy), 32'h0);

        // Remote mode: ch2 falls at 0, 3, 6; local presses ignored
        local_en = 1'b0;
        tick();
        for (int j = 0; j < 15; j++) begin
            btn_remote = (j == 0 || j == 3 || j == 6) ? 3'b011 : 3'b111;
            case (j)
                1, 2:    btn_local = 3'b110;
                4:       btn_local = 3'b011;
                default: btn_local = 3'b111;
            endcase
            tick();
            exp_p = (j == 2 || j == 5 || j == 8) ? 3'b100 : 3'b000;
            chk("remote_pulse", 32'(pulse), 32'(exp_p));
            chk("remote_busy", 32'(busy), 32'h0);
            if (j == 2) chk("remote_idx", 32'(event_idx), 32'h2);
        end
        local_en = 1'b1;
        repeat (2) tick();

        // Reset during lockout, button held through reset release
        btn_local = 3'b110;
        repeat (3) tick();
        chk("rstseq_pulse", 32'(pulse), 32'h1);
        repeat (2) tick();
        chk("rstseq_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        tick();
        chk("rstseq_busy_clr", 32'(busy), 32'h0);
        chk("rstseq_pulse_clr", 32'(pulse), 32'h0);
        chk("rstseq_valid_clr", 32'(event_valid), 32'h0);
        chk("rstseq_level", 32'(level), 32'h7);
        repeat (2) tick();
        rst = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("held_no_pulse", 32'(event_valid), 32'h0);
        end
        btn_local = 3'b111;
        repeat (3) tick();
        btn_local = 3'b110;
        repeat (3) tick();
        chk("repress_pulse", 32'(pulse), 32'h1);
        btn_local = 3'b111;
        tick();

        // Sweep instance: 8 channels, no lockout, 3 sync stages, rising edges
        for (int j = 0; j < 10; j++) begin
            b8l = (j == 0 || j == 2) ? 8'h80 : 8'h00;
            tick();
            exp_p8 = (j == 3 || j == 5) ? 8'h80 : 8'h00;
            chk("sweep_pulse", 32'(pulse8), 32'(exp_p8));
            chk("sweep_busy", 32'(busy8), 32'h0);
            if (j == 3) begin
                chk("sweep_idx", 32'(idx8), 32'h7);
                chk("sweep_valid", 32'(ev8), 32'h1);
            end
        end
        chk("sweep_level", 32'(level8), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
